// File: rtl/ipbb_rst_seq_gen.sv
// Reset sequencer: holds a downstream reset for a minimum width, then handshakes assert/deassert via rst_ack.
// Optional ack-wait timeout enabled by defining IPBB_RST_SEQ_TIMEOUT_EN.
module ipbb_rst_seq_gen #(
  parameter int RST_HOLD_CYC    = 16,
  parameter int ACK_TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic syn_rst,
  input  logic rst_req,
  input  logic rst_ack,
  output logic rst_out,
  output logic rst_busy,
  output logic rst_done,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD       = 3'd1,
    WAIT_ACK   = 3'd2,
    RELEASE    = 3'd3,
    WAIT_DEACK = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYC - 1);

  if (RST_HOLD_CYC < 1 || RST_HOLD_CYC > 65535 ||
      ACK_TIMEOUT_CYC < 1 || ACK_TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("ipbb_rst_seq_gen: parameter out of range 1..65535");
  end

`ifdef IPBB_RST_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT_CYC - 1);
`else
  assign timeout_err = 1'b0;
`endif

  state_t      state_r;
  logic [15:0] cnt_r;

  // Sequencer state, hold/timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      rst_out     <= 1'b1;
      rst_busy    <= 1'b0;
      rst_done    <= 1'b0;
`ifdef IPBB_RST_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      rst_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rst_req) begin
            state_r  <= HOLD;
            cnt_r    <= 16'd0;
            rst_out  <= 1'b1;
            rst_busy <= 1'b1;
          end else begin
            rst_out  <= 1'b0;
            rst_busy <= 1'b0;
          end
        end

        HOLD: begin
          rst_out  <= 1'b1;
          rst_busy <= 1'b1;
          if (cnt_r == HOLD_LAST) begin
            state_r <= WAIT_ACK;
            cnt_r   <= 16'd0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        WAIT_ACK: begin
          rst_busy <= 1'b1;
          if (rst_ack) begin
            state_r <= RELEASE;
            cnt_r   <= 16'd0;
            rst_out <= 1'b1;
          end
`ifdef IPBB_RST_SEQ_TIMEOUT_EN
          else if (cnt_r == TO_LAST) begin
            state_r     <= DONE;
            rst_out     <= 1'b0;
            rst_done    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            rst_out <= 1'b1;
          end
`else
          else begin
            rst_out <= 1'b1;
          end
`endif
        end

        RELEASE: begin
          rst_busy <= 1'b1;
          if (rst_req) begin
            rst_out <= 1'b1;
          end else begin
            state_r <= WAIT_DEACK;
            cnt_r   <= 16'd0;
            rst_out <= 1'b0;
          end
        end

        WAIT_DEACK: begin
          rst_busy <= 1'b1;
          // A fresh request wins over completion and restarts the full hold
          if (rst_req) begin
            state_r <= HOLD;
            cnt_r   <= 16'd0;
            rst_out <= 1'b1;
          end else if (!rst_ack) begin
            state_r  <= DONE;
            rst_out  <= 1'b0;
            rst_done <= 1'b1;
          end
`ifdef IPBB_RST_SEQ_TIMEOUT_EN
          else if (cnt_r == TO_LAST) begin
            state_r     <= DONE;
            rst_out     <= 1'b0;
            rst_done    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            rst_out <= 1'b0;
          end
`else
          else begin
            rst_out <= 1'b0;
          end
`endif
        end

        DONE: begin
          state_r  <= IDLE;
          cnt_r    <= 16'd0;
          rst_out  <= 1'b0;
          rst_busy <= 1'b0;
        end

        default: begin
          state_r  <= IDLE;
          cnt_r    <= 16'd0;
          rst_out  <= 1'b1;
          rst_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipbb_rst_seq_gen.sv
// Directed self-checking bench for ipbb_rst_seq_gen (RST_HOLD_CYC=4, ACK_TIMEOUT_CYC=8).
module tb_ipbb_rst_seq_gen;

  logic clk = 1'b0;
  logic syn_rst, rst_req, rst_ack;
  logic rst_out, rst_busy, rst_done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int out_hi   = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  ipbb_rst_seq_gen #(
    .RST_HOLD_CYC   (4),
    .ACK_TIMEOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .syn_rst    (syn_rst),
    .rst_req    (rst_req),
    .rst_ack    (rst_ack),
    .rst_out    (rst_out),
    .rst_busy   (rst_busy),
    .rst_done   (rst_done),
    .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge and accumulate observations.
  task automatic tick();
    @(posedge clk);
    #1;
    out_hi    = out_hi + 32'(rst_out);
    done_seen = done_seen + 32'(rst_done);
  endtask

  task automatic clr();
    out_hi    = 0;
    done_seen = 0;
  endtask

  initial begin
    syn_rst = 1'b1;
    rst_req = 1'b0;
    rst_ack = 1'b0;
    tick();
    tick();
    check_eq("rst_out_in_reset", 32'(rst_out), 32'd1);
    check_eq("busy_in_reset", 32'(rst_busy), 32'd0);
    check_eq("done_in_reset", 32'(rst_done), 32'd0);
    check_eq("err_in_reset", 32'(timeout_err), 32'd0);
    syn_rst = 1'b0;
    check_eq("rst_out_first_after_reset", 32'(rst_out), 32'd1);
    tick();
    check_eq("rst_out_idle", 32'(rst_out), 32'd0);

    // Nominal: req for 2 cycles, ack rises 6 cycles after rst_out, drops later
    clr();
    rst_req = 1'b1;
    tick();
    check_eq("nom_req_to_out", 32'(rst_out), 32'd1);
    check_eq("nom_busy", 32'(rst_busy), 32'd1);
    tick();
    rst_req = 1'b0;
    repeat (4) tick();
    check_eq("nom_out_wait_ack", 32'(rst_out), 32'd1);
    rst_ack = 1'b1;
    tick();
    check_eq("nom_out_release", 32'(rst_out), 32'd1);
    tick();
    check_eq("nom_out_deack", 32'(rst_out), 32'd0);
    tick();
    check_eq("nom_no_done_ack_hi", 32'(rst_done), 32'd0);
    rst_ack = 1'b0;
    tick();
    check_eq("nom_done_pulse", 32'(rst_done), 32'd1);
    tick();
    check_eq("nom_done_clear", 32'(rst_done), 32'd0);
    check_eq("nom_busy_clear", 32'(rst_busy), 32'd0);
    // HOLD 4 + WAIT_ACK 2 + RELEASE 1
    check_eq("nom_out_len", 32'(out_hi), 32'd7);
    check_eq("nom_done_count", 32'(done_seen), 32'd1);

    // Hold minimum: 1-cycle req, ack tied high
    clr();
    rst_ack = 1'b1;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    repeat (5) tick();
    check_eq("min_out_release", 32'(rst_out), 32'd1);
    tick();
    check_eq("min_out_low", 32'(rst_out), 32'd0);
    repeat (5) tick();
    check_eq("min_no_done", 32'(done_seen), 32'd0);
    check_eq("min_busy", 32'(rst_busy), 32'd1);
    // HOLD 4 + WAIT_ACK 1 + RELEASE 1
    check_eq("min_out_len", 32'(out_hi), 32'd6);
    rst_ack = 1'b0;
    tick();
    check_eq("min_done_pulse", 32'(rst_done), 32'd1);
    tick();
    check_eq("min_busy_clear", 32'(rst_busy), 32'd0);

    // Re-request while waiting for ack deassertion
    clr();
    rst_ack = 1'b1;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    repeat (6) tick();
    check_eq("rereq_out_low", 32'(rst_out), 32'd0);
    rst_req = 1'b1;
    tick();
    check_eq("rereq_out_again", 32'(rst_out), 32'd1);
    rst_req = 1'b0;
    repeat (6) tick();
    check_eq("rereq_out_low2", 32'(rst_out), 32'd0);
    check_eq("rereq_no_done", 32'(done_seen), 32'd0);
    rst_ack = 1'b0;
    tick();
    check_eq("rereq_done_pulse", 32'(rst_done), 32'd1);
    tick();
    check_eq("rereq_busy_clear", 32'(rst_busy), 32'd0);
    check_eq("rereq_done_count", 32'(done_seen), 32'd1);

    // Ack never arrives
    clr();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    repeat (4) tick();
`ifdef IPBB_RST_SEQ_TIMEOUT_EN
    repeat (7) tick();
    check_eq("to_not_yet", 32'(timeout_err), 32'd0);
    check_eq("to_out_hi", 32'(rst_out), 32'd1);
    tick();
    check_eq("to_err_set", 32'(timeout_err), 32'd1);
    check_eq("to_done_pulse", 32'(rst_done), 32'd1);
    check_eq("to_out_low", 32'(rst_out), 32'd0);
    tick();
    check_eq("to_idle", 32'(rst_busy), 32'd0);
    repeat (5) tick();
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
    syn_rst = 1'b1;
    tick();
    check_eq("to_err_cleared", 32'(timeout_err), 32'd0);
    syn_rst = 1'b0;
    tick();
`else
    repeat (20) tick();
    check_eq("noto_err", 32'(timeout_err), 32'd0);
    check_eq("noto_out_hi", 32'(rst_out), 32'd1);
    check_eq("noto_busy", 32'(rst_busy), 32'd1);
    rst_ack = 1'b1;
    tick();
    tick();
    rst_ack = 1'b0;
    tick();
    check_eq("noto_done_pulse", 32'(rst_done), 32'd1);
    tick();
    check_eq("noto_done_count", 32'(done_seen), 32'd1);
`endif

    // syn_rst in the middle of HOLD
    clr();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    syn_rst = 1'b1;
    tick();
    check_eq("mid_out_hi", 32'(rst_out), 32'd1);
    check_eq("mid_busy_low", 32'(rst_busy), 32'd0);
    syn_rst = 1'b0;
    check_eq("mid_out_hold_after", 32'(rst_out), 32'd1);
    tick();
    check_eq("mid_out_released", 32'(rst_out), 32'd0);
    repeat (8) tick();
    check_eq("mid_no_done", 32'(done_seen), 32'd0);
    check_eq("mid_idle", 32'(rst_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
